// File: rtl/world_pkg.sv
// Shared definitions for the world-map write path: cell codes, request
// kinds, writer FSM states and the cell replacement rule.
package world_pkg;

  localparam int ADDR_W  = 11;
  localparam int KIND_W  = 2;
  localparam int ENTRY_W = ADDR_W + KIND_W;

  typedef logic [4:0] cell_code_t;

  // bit0 == 0 marks a solid cell
  localparam cell_code_t CELL_EMPTY  = 5'd1;
  localparam cell_code_t CELL_BRICK  = 5'd2;
  localparam cell_code_t CELL_COIN   = 5'd3;
  localparam cell_code_t CELL_QBLOCK = 5'd4;
  localparam cell_code_t CELL_USED   = 5'd6;

  typedef enum logic [1:0] {
    BUMP    = 2'd0,
    BREAK   = 2'd1,
    COLLECT = 2'd2,
    RSVD    = 2'd3
  } req_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_DECIDE   = 3'd2,
    ST_WAIT_WIN = 3'd3,
    ST_WRITE    = 3'd4
  } writer_state_t;

  // FIFO entry layout {kind, addr}
  typedef struct packed {
    req_kind_t         kind;
    logic [ADDR_W-1:0] addr;
  } cell_req_t;

  typedef struct packed {
    logic       do_write;
    logic       coin;
    cell_code_t code;
  } decision_t;

  // Replacement rule: which (kind, current code) pairs modify the map
  function automatic decision_t decide_cell(req_kind_t kind, cell_code_t code);
    decision_t d;
    d = '0;
    if (kind == BUMP && code == CELL_QBLOCK) begin
      d.do_write = 1'b1;
      d.coin     = 1'b1;
      d.code     = CELL_USED;
    end else if (kind == BREAK && code == CELL_BRICK) begin
      d.do_write = 1'b1;
      d.code     = CELL_EMPTY;
    end else if (kind == COLLECT && code == CELL_COIN) begin
      d.do_write = 1'b1;
      d.coin     = 1'b1;
      d.code     = CELL_EMPTY;
    end
    return d;
  endfunction

endpackage

// File: rtl/world_cell_writer_if.sv
// Request handshake between gameplay logic (master) and the cell writer (slave).
interface world_cell_writer_if;
  import world_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_cell_addr;
  logic [KIND_W-1:0] req_kind;

  modport master (
    output req_valid,
    output req_cell_addr,
    output req_kind,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_cell_addr,
    input  req_kind,
    output req_ready
  );

endinterface

// File: rtl/world_cell_writer_req_fifo.sv
// Small synchronous request FIFO with registered full/empty flags.
// Head entry is visible on pop_data whenever empty is low.
module req_fifo
  import world_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count - 1'b1;
    end
  end

  // Storage write; contents need no reset since flags gate visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and flags; reset flushes the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (PTR_W + 1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/world_cell_writer.sv
// World-map cell writer: queues cell-modification requests, reads the
// current cell code, applies the replacement rule and commits the write
// only while the write window (wr_allow) is open.
// Optional build macro WORLD_WRITER_DEDUP_EN: drop repeat requests to the
// same address within one frame before they reach the FIFO.
module world_cell_writer
  import world_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAP_CELLS  = 1200,
  parameter int RD_LAT     = 1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  world_cell_writer_if.slave       req,
  input  logic                     wr_allow,
  output logic [ADDR_W-1:0]        ram_rd_addr,
  input  cell_code_t               ram_rd_data,
  output logic                     ram_wr_en,
  output logic [ADDR_W-1:0]        ram_wr_addr,
  output cell_code_t               ram_wr_data,
  output logic                     coin_pulse,
  output logic                     err_pulse,
  output logic                     busy
);

  localparam logic [ADDR_W:0] MAP_LIMIT = (ADDR_W + 1)'(MAP_CELLS);
  localparam logic [1:0]      LAT_LAST  = 2'(RD_LAT - 1);

  writer_state_t     state;
  writer_state_t     state_next;
  logic [ADDR_W-1:0] addr_reg;
  req_kind_t         kind_reg;
  cell_code_t        wr_data_reg;
  logic              coin_reg;
  logic              err_reg;
  logic [1:0]        lat_cnt;

  logic              accept;
  logic              dup;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  cell_req_t         head;
  logic              head_ok;
  decision_t         dec;

  assign req.req_ready = !fifo_full;
  assign accept        = req.req_valid && req.req_ready;
  assign fifo_push     = accept && !dup;

`ifdef WORLD_WRITER_DEDUP_EN
  logic [ADDR_W-1:0] last_addr;
  logic              last_valid;
  logic              wr_allow_d;

  assign dup = last_valid && (req.req_cell_addr == last_addr);

  // Remember the last enqueued address; a new frame (window opening) forgets it
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_addr  <= '0;
      last_valid <= 1'b0;
      wr_allow_d <= 1'b0;
    end else begin
      wr_allow_d <= wr_allow;
      if (wr_allow && !wr_allow_d) last_valid <= 1'b0;
      if (fifo_push) begin
        last_addr  <= req.req_cell_addr;
        last_valid <= 1'b1;
      end
    end
  end
`else
  assign dup = 1'b0;
`endif

  req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .push      (fifo_push),
    .push_data ({req.req_kind, req.req_cell_addr}),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Invalid requests are rejected at the FIFO head, before any RAM access
  assign head_ok = ({1'b0, head.addr} < MAP_LIMIT) && (head.kind != RSVD);
  assign dec     = decide_cell(kind_reg, ram_rd_data);

  assign ram_rd_addr = addr_reg;
  assign ram_wr_addr = addr_reg;
  assign ram_wr_data = wr_data_reg;
  assign coin_pulse  = ram_wr_en && coin_reg;
  assign err_pulse   = err_reg;
  assign busy        = (state != ST_IDLE) || !fifo_empty;

  // Next-state and strobes; the write strobe is gated by the live window
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    ram_wr_en  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_ok) state_next = ST_READ;
        end
      end
      ST_READ: begin
        if (lat_cnt == LAT_LAST) state_next = ST_DECIDE;
      end
      ST_DECIDE: begin
        // Window already open: go straight to the write to keep the period short
        if (!dec.do_write)  state_next = ST_IDLE;
        else if (wr_allow)  state_next = ST_WRITE;
        else                state_next = ST_WAIT_WIN;
      end
      ST_WAIT_WIN: begin
        if (wr_allow) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (wr_allow) begin
          ram_wr_en  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WAIT_WIN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register, request latch, decision latch and error pulse
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      addr_reg    <= '0;
      kind_reg    <= BUMP;
      wr_data_reg <= '0;
      coin_reg    <= 1'b0;
      err_reg     <= 1'b0;
      lat_cnt     <= '0;
    end else begin
      state   <= state_next;
      err_reg <= fifo_pop && !head_ok;
      lat_cnt <= (state == ST_READ) ? lat_cnt + 1'b1 : 2'd0;
      if (fifo_pop && head_ok) begin
        addr_reg <= head.addr;
        kind_reg <= head.kind;
      end
      if (state == ST_DECIDE) begin
        wr_data_reg <= dec.code;
        coin_reg    <= dec.coin;
      end
    end
  end

endmodule

// File: tb/tb_world_cell_writer.sv
// Directed bench for world_cell_writer: table of single requests plus
// hand-written sequences for window wait, FIFO fill, dedup and reset.
module tb_world_cell_writer;
  import world_pkg::*;

  localparam int MAP_CELLS = 1200;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        wr_allow = 1'b0;
  logic [10:0] ram_rd_addr;
  cell_code_t  ram_rd_data;
  logic        ram_wr_en;
  logic [10:0] ram_wr_addr;
  cell_code_t  ram_wr_data;
  logic        coin_pulse;
  logic        err_pulse;
  logic        busy;

  world_cell_writer_if rq ();

  world_cell_writer #(
    .FIFO_DEPTH (4),
    .MAP_CELLS  (MAP_CELLS),
    .RD_LAT     (1)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .req         (rq),
    .wr_allow    (wr_allow),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .coin_pulse  (coin_pulse),
    .err_pulse   (err_pulse),
    .busy        (busy)
  );

  always #10 Clk = ~Clk;

  // World RAM model, one-cycle read latency
  cell_code_t mem [0:2047];
  always @(posedge Clk) ram_rd_data <= mem[ram_rd_addr];

  // Monitor on the falling edge: count strobes and log writes
  int          wr_count = 0, coin_count = 0, err_count = 0, bad_wr = 0, bad_rd = 0;
  logic [10:0] wr_addr_log [$];
  cell_code_t  wr_data_log [$];
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (ram_wr_en) begin
        wr_count++;
        wr_addr_log.push_back(ram_wr_addr);
        wr_data_log.push_back(ram_wr_data);
        if (!wr_allow) bad_wr++;
        $display("write addr=%0d data=%0d coin=%0b", ram_wr_addr, ram_wr_data, coin_pulse);
      end
      if (coin_pulse) coin_count++;
      if (err_pulse) err_count++;
      if (int'(ram_rd_addr) >= MAP_CELLS) bad_rd++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present a request; accepted when req_ready is high at the clock edge
  task automatic push(input logic [10:0] a, input logic [1:0] k, input int budget, output bit ok);
    ok = 1'b0;
    rq.req_valid     = 1'b1;
    rq.req_cell_addr = a;
    rq.req_kind      = k;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge Clk);
      if (rq.req_ready) ok = 1'b1;
      tick();
    end
    rq.req_valid = 1'b0;
    $display("push addr=%0d kind=%0d accepted=%0b", a, k, ok);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, int'(n < 300), 1);
    tick();
    tick();
  endtask

  typedef struct {
    logic [10:0] addr;
    logic [1:0]  kind;
    cell_code_t  code;
    int          exp_wr;
    cell_code_t  exp_data;
    int          exp_coin;
    int          exp_err;
    string       name;
  } vec_t;

  function automatic vec_t mk(logic [10:0] a, logic [1:0] k, cell_code_t c, int w,
                              cell_code_t d, int cn, int e, string n);
    vec_t v;
    v.addr = a; v.kind = k; v.code = c; v.exp_wr = w;
    v.exp_data = d; v.exp_coin = cn; v.exp_err = e; v.name = n;
    return v;
  endfunction

  vec_t vecs [10];

  initial begin
    bit ok;
    int w0, c0, e0, acc;

    rq.req_valid = 1'b0;
    rq.req_cell_addr = '0;
    rq.req_kind = '0;
    for (int i = 0; i < 2048; i++) mem[i] = CELL_EMPTY;

    vecs[0] = mk(11'd45,   2'd0, CELL_QBLOCK, 1, CELL_USED,  1, 0, "bump_qblock");
    vecs[1] = mk(11'd60,   2'd1, CELL_QBLOCK, 0, 5'd0,       0, 0, "break_qblock");
    vecs[2] = mk(11'd61,   2'd2, CELL_EMPTY,  0, 5'd0,       0, 0, "collect_empty");
    vecs[3] = mk(11'd62,   2'd2, CELL_COIN,   1, CELL_EMPTY, 1, 0, "collect_coin");
    vecs[4] = mk(11'd63,   2'd1, CELL_BRICK,  1, CELL_EMPTY, 0, 0, "break_brick");
    vecs[5] = mk(11'd64,   2'd0, CELL_USED,   0, 5'd0,       0, 0, "bump_used");
    vecs[6] = mk(11'd1200, 2'd0, CELL_QBLOCK, 0, 5'd0,       0, 1, "addr_1200");
    vecs[7] = mk(11'd10,   2'd3, CELL_QBLOCK, 0, 5'd0,       0, 1, "kind_rsvd");
    vecs[8] = mk(11'd1199, 2'd1, CELL_BRICK,  1, CELL_EMPTY, 0, 0, "break_last_cell");
    vecs[9] = mk(11'd2047, 2'd2, CELL_COIN,   0, 5'd0,       0, 1, "addr_max");
    for (int i = 0; i < 10; i++) mem[vecs[i].addr] = vecs[i].code;

    // Reset state
    #1 Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_req_ready", int'(rq.req_ready), 1);
    check("rst_wr_en", int'(ram_wr_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_coin", int'(coin_pulse), 0);
    check("rst_err", int'(err_pulse), 0);
    check("rst_rd_addr", int'(ram_rd_addr), 0);
    check("rst_wr_addr", int'(ram_wr_addr), 0);
    check("rst_wr_data", int'(ram_wr_data), 0);
    tick();
    Reset_n = 1'b1;
    wr_allow = 1'b1;
    tick();

    // Single-request table with the window open
    for (int i = 0; i < 10; i++) begin
      w0 = wr_count; c0 = coin_count; e0 = err_count;
      push(vecs[i].addr, vecs[i].kind, 10, ok);
      check({vecs[i].name, "_accept"}, int'(ok), 1);
      wait_idle(vecs[i].name);
      check({vecs[i].name, "_writes"}, wr_count - w0, vecs[i].exp_wr);
      check({vecs[i].name, "_coins"}, coin_count - c0, vecs[i].exp_coin);
      check({vecs[i].name, "_errs"}, err_count - e0, vecs[i].exp_err);
      check({vecs[i].name, "_busy"}, int'(busy), 0);
      if (wr_addr_log.size() > w0) begin
        check({vecs[i].name, "_wr_addr"}, int'(wr_addr_log[w0]), int'(vecs[i].addr));
        check({vecs[i].name, "_wr_data"}, int'(wr_data_log[w0]), int'(vecs[i].exp_data));
      end
    end

    // Write held off while the window is closed, issued right after it opens
    wr_allow = 1'b0;
    mem[100] = CELL_BRICK;
    w0 = wr_count;
    push(11'd100, 2'd1, 10, ok);
    check("win_accept", int'(ok), 1);
    repeat (50) tick();
    check("win_no_write_closed", wr_count - w0, 0);
    check("win_busy_pending", int'(busy), 1);
    wr_allow = 1'b1;
    @(negedge Clk);
    check("win_rise_cycle_wr_en", int'(ram_wr_en), 0);
    @(negedge Clk);
    check("win_next_cycle_wr_en", int'(ram_wr_en), 1);
    check("win_wr_addr", int'(ram_wr_addr), 100);
    check("win_wr_data", int'(ram_wr_data), int'(CELL_EMPTY));
    check("win_coin", int'(coin_pulse), 0);
    tick();
    wait_idle("win");
    check("win_total_writes", wr_count - w0, 1);

    // Fill the FIFO while the first request waits for the window
    wr_allow = 1'b0;
    for (int i = 0; i < 6; i++) mem[200 + i] = CELL_BRICK;
    w0 = wr_count;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      push(11'(200 + i), 2'd1, 3, ok);
      acc += int'(ok);
    end
    check("fill_accepted", acc, 5);
    @(negedge Clk);
    check("fill_ready_low", int'(rq.req_ready), 0);
    tick();
    push(11'd205, 2'd1, 3, ok);
    check("fill_sixth_refused", int'(ok), 0);
    wr_allow = 1'b1;
    tick();
    wait_idle("fill");
    check("fill_writes", wr_count - w0, 5);
    for (int i = 0; i < 5; i++) begin
      if (wr_addr_log.size() > w0 + i) begin
        check("fill_order_addr", int'(wr_addr_log[w0 + i]), 200 + i);
        check("fill_order_data", int'(wr_data_log[w0 + i]), int'(CELL_EMPTY));
      end
    end
    check("fill_ready_back", int'(rq.req_ready), 1);

`ifdef WORLD_WRITER_DEDUP_EN
    // Repeat flags within one frame collapse to a single write
    wr_allow = 1'b0;
    mem[45] = CELL_QBLOCK;
    tick();
    w0 = wr_count; acc = 0;
    for (int i = 0; i < 3; i++) begin
      push(11'd45, 2'd0, 5, ok);
      acc += int'(ok);
    end
    check("dedup_accepted", acc, 3);
    repeat (5) tick();
    wr_allow = 1'b1;
    tick();
    wait_idle("dedup");
    check("dedup_writes", wr_count - w0, 1);
`endif

    // Reset in the middle of a pending write flushes everything
    wr_allow = 1'b0;
    mem[300] = CELL_BRICK;
    mem[301] = CELL_BRICK;
    push(11'd300, 2'd1, 5, ok);
    push(11'd301, 2'd1, 5, ok);
    repeat (10) tick();
    check("rst_mid_busy", int'(busy), 1);
    wr_allow = 1'b1;
    tick();
    check("rst_mid_wr_en_before", int'(ram_wr_en), 1);
    Reset_n = 1'b0;
    #1;
    check("rst_mid_wr_en_drop", int'(ram_wr_en), 0);
    check("rst_mid_ready", int'(rq.req_ready), 1);
    check("rst_mid_busy_clear", int'(busy), 0);
    tick();
    Reset_n = 1'b1;
    w0 = wr_count;
    repeat (20) tick();
    check("rst_mid_no_writes", wr_count - w0, 0);
    check("rst_mid_idle", int'(busy), 0);

    check("never_write_closed", bad_wr, 0);
    check("rd_addr_in_range", bad_rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
